// File: rtl/alu_pkg.sv
// Shared definitions for the serial nibble adder: FSM state encoding,
// nibble width and the single-nibble add helper.
package alu_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  // Adds two nibbles plus carry; returns {carry, sum}.
  function automatic logic [NIBBLE_W:0] nibble_add(
    input logic [NIBBLE_W-1:0] x,
    input logic [NIBBLE_W-1:0] y,
    input logic                cin
  );
    nibble_add = {1'b0, x} + {1'b0, y} + {{NIBBLE_W{1'b0}}, cin};
  endfunction

endpackage

// File: rtl/alu_adder_half.sv
// One-nibble adder slice used by the serial adder; outputs are forced to
// zero when the slice is disabled.
module alu_adder_half
  import alu_pkg::*;
(
  input  logic                en_i,
  input  logic [NIBBLE_W-1:0] a_i,
  input  logic [NIBBLE_W-1:0] b_i,
  input  logic                carry_i,
  output logic [NIBBLE_W-1:0] sum_o,
  output logic                carry_o
);

  // Combinational nibble sum with carry in/out.
  always_comb begin
    sum_o   = {NIBBLE_W{1'b0}};
    carry_o = 1'b0;
    if (en_i) begin
      {carry_o, sum_o} = nibble_add(a_i, b_i, carry_i);
    end else begin
      sum_o   = {NIBBLE_W{1'b0}};
      carry_o = 1'b0;
    end
  end

endmodule

// File: rtl/alu_serial_adder.sv
// Serial add/subtract unit: processes one nibble per cycle, NIBBLES cycles
// per operation, with a valid/ready handshake on both sides.
// Optional build macro ALU_SERIAL_FLAGS_EN enables the zero/overflow flags;
// without it both flag ports are tied to 0.
module alu_serial_adder
  import alu_pkg::*;
#(
  parameter int NIBBLES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0] a,
  input  logic [NIBBLE_W*NIBBLES-1:0] b,
  input  logic                       carry_in,
  input  logic                       op_sub,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NIBBLE_W*NIBBLES-1:0] result,
  output logic                       carry_out,
  output logic                       zero,
  output logic                       overflow
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic             carry_q, carry_d;
  logic [W-1:0]     result_q, result_d;

  logic [NIBBLE_W-1:0] nib_a_s;
  logic [NIBBLE_W-1:0] nib_b_s;
  logic [NIBBLE_W-1:0] nib_sum_s;
  logic                nib_carry_s;
  logic                last_nib_s;

  assign nib_a_s    = a_q[idx_q*NIBBLE_W +: NIBBLE_W];
  assign nib_b_s    = b_q[idx_q*NIBBLE_W +: NIBBLE_W];
  assign last_nib_s = (state_q == RUN) && (idx_q == LAST_IDX);

  alu_adder_half u_half (
    .en_i    (1'b1),
    .a_i     (nib_a_s),
    .b_i     (nib_b_s),
    .carry_i (carry_q),
    .sum_o   (nib_sum_s),
    .carry_o (nib_carry_s)
  );

  // Next-state logic: accept in IDLE, one nibble per RUN cycle, hold in DONE.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    carry_d  = carry_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = op_sub ? ~b : b;
          carry_d = op_sub ? 1'b1 : carry_in;
          idx_d   = {IDX_W{1'b0}};
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        result_d[idx_q*NIBBLE_W +: NIBBLE_W] = nib_sum_s;
        carry_d = nib_carry_s;
        if (idx_q == LAST_IDX) begin
          idx_d   = {IDX_W{1'b0}};
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = {IDX_W{1'b0}};
      end
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= {IDX_W{1'b0}};
      a_q      <= {W{1'b0}};
      b_q      <= {W{1'b0}};
      carry_q  <= 1'b0;
      result_q <= {W{1'b0}};
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      carry_q  <= carry_d;
      result_q <= result_d;
    end
  end

`ifdef ALU_SERIAL_FLAGS_EN
  logic zero_q, zero_d;
  logic ovf_q, ovf_d;

  // Flags are evaluated from the complete result as the last nibble lands.
  always_comb begin
    zero_d = zero_q;
    ovf_d  = ovf_q;
    if (last_nib_s) begin
      zero_d = (result_d == {W{1'b0}});
      ovf_d  = (a_q[W-1] == b_q[W-1]) && (result_d[W-1] != a_q[W-1]);
    end else begin
      zero_d = zero_q;
      ovf_d  = ovf_q;
    end
  end

  // Flag registers, captured on entry to DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      zero_q <= zero_d;
      ovf_q  <= ovf_d;
    end
  end

  assign zero     = zero_q;
  assign overflow = ovf_q;
`else
  assign zero     = 1'b0;
  assign overflow = 1'b0;
`endif

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign carry_out = carry_q;

endmodule

// File: tb/tb_alu_serial_adder.sv
// Self-checking bench for alu_serial_adder (NIBBLES = 2): directed cases with
// hand-computed values plus random operations checked every cycle against
// an arithmetic reference model.
module tb_alu_serial_adder;

  localparam int NIBBLES = 2;
  localparam int W       = 4 * NIBBLES;
`ifdef ALU_SERIAL_FLAGS_EN
  localparam bit FLAGS_ON = 1'b1;
`else
  localparam bit FLAGS_ON = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_s;
  logic [W-1:0] b_s;
  logic         carry_in;
  logic         op_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carry_out;
  logic         zero;
  logic         overflow;

  int total = 0;
  int bad   = 0;

  alu_serial_adder #(.NIBBLES(NIBBLES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a_s),
    .b         (b_s),
    .carry_in  (carry_in),
    .op_sub    (op_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry_out (carry_out),
    .zero      (zero),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Arithmetic reference: returns {overflow, zero, carry, result}.
  function automatic logic [W+2:0] calc(input logic [W-1:0] x, input logic [W-1:0] y,
                                        input logic ci, input logic sub);
    logic [W-1:0] ye;
    logic [W:0]   s;
    logic         z;
    logic         ov;
    ye = sub ? ~y : y;
    s  = {1'b0, x} + {1'b0, ye} + (sub ? (W+1)'(1) : (W+1)'(ci));
    z  = (s[W-1:0] == '0);
    ov = (x[W-1] == ye[W-1]) && (s[W-1] != x[W-1]);
    return {ov, z, s[W], s[W-1:0]};
  endfunction

  // Reference model: phase 0 idle, 1 computing (latency countdown), 2 result held.
  int           m_phase;
  int           m_cnt;
  logic [W+2:0] m_exp;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0;
      m_cnt   <= 0;
    end else begin
      case (m_phase)
        0: if (in_valid) begin
             m_exp   <= calc(a_s, b_s, carry_in, op_sub);
             m_phase <= 1;
             m_cnt   <= NIBBLES;
           end
        1: if (m_cnt == 1) m_phase <= 2; else m_cnt <= m_cnt - 1;
        2: if (out_ready) m_phase <= 0;
        default: m_phase <= 0;
      endcase
    end
  end

  // Compare DUT against the model on every falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      check("in_ready", 32'(in_ready), 32'(m_phase == 0));
      check("out_valid", 32'(out_valid), 32'(m_phase == 2));
      if (m_phase == 2) begin
        check("m_result", 32'(result), 32'(m_exp[W-1:0]));
        check("m_carry", 32'(carry_out), 32'(m_exp[W]));
        check("m_zero", 32'(zero), FLAGS_ON ? 32'(m_exp[W+1]) : 32'd0);
        check("m_ovf", 32'(overflow), FLAGS_ON ? 32'(m_exp[W+2]) : 32'd0);
      end
    end
  end

  // Runs one operation from IDLE with literal expectations; holds the
  // result for 'hold' cycles with a competing request before draining.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci,
                        input logic sub, input logic [W-1:0] er, input logic eco,
                        input logic ez, input logic eov, input int hold);
    int lat;
    logic [W-1:0] r0;
    logic c0, z0, o0;
    @(negedge clk);
    a_s = av; b_s = bv; carry_in = ci; op_sub = sub; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a_s = W'($urandom); b_s = W'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin
      lat++;
      @(negedge clk);
    end
    check("latency", 32'(lat), 32'(NIBBLES));
    check("result", 32'(result), 32'(er));
    check("carry_out", 32'(carry_out), 32'(eco));
    check("zero", 32'(zero), FLAGS_ON ? 32'(ez) : 32'd0);
    check("overflow", 32'(overflow), FLAGS_ON ? 32'(eov) : 32'd0);
    r0 = result; c0 = carry_out; z0 = zero; o0 = overflow;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      a_s = W'($urandom); b_s = W'($urandom); op_sub = 1'($urandom);
      @(negedge clk);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_ready", 32'(in_ready), 32'd0);
      check("hold_stable", {20'd0, o0, z0, c0, r0}, {20'd0, overflow, zero, carry_out, result});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("drain_idle", {30'd0, in_ready, out_valid}, 32'b10);
  endtask

  logic [W+2:0] e;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a_s = '0; b_s = '0;
    carry_in = 1'b0; op_sub = 1'b0; out_ready = 1'b0;
    #12;
    check("rst_outputs", {20'd0, out_valid, zero, overflow, carry_out, result}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Pin the reference model on hand-computed values.
    check("model_add", 32'(calc(8'h3A, 8'h47, 1'b0, 1'b0)), 32'(11'b100_1000_0001));
    check("model_sub", 32'(calc(8'h80, 8'h01, 1'b0, 1'b1)), 32'(11'b101_0111_1111));

    run_op(8'h3A, 8'h47, 1'b0, 1'b0, 8'h81, 1'b0, 1'b0, 1'b1, 0);
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 0);
    run_op(8'h0F, 8'h00, 1'b1, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0, 1);
    run_op(8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1, 1'b0, 1'b0, 0);
    run_op(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b0, 1'b1, 0);
    run_op(8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 5);

    // Reset after the first nibble has been written.
    @(negedge clk);
    a_s = 8'h3A; b_s = 8'h47; carry_in = 1'b0; op_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check("midrun_rst", {20'd0, out_valid, zero, overflow, carry_out, result}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", {30'd0, in_ready, out_valid}, 32'b10);
    run_op(8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, 0);

    // Random operations with random result back-pressure.
    for (int k = 0; k < 40; k++) begin
      logic [W-1:0] ra, rb;
      logic rc, rs;
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom); rs = 1'($urandom);
      e = calc(ra, rb, rc, rs);
      run_op(ra, rb, rc, rs, e[W-1:0], e[W], e[W+1], e[W+2], int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
